// File: rtl/control_cmd.sv
// control_cmd: INIT -> RUN -> DONE sequencer that counts prescaled ticks up to LIMIT.
// Ports:
//   iClock         rising-edge clock
//   iReset         asynchronous active-high reset
//   oPaseePorReset sticky flag, set by reset and never cleared by logic
//   oData          current count (0..LIMIT, never wraps)
//   oValid         one-cycle strobe accompanying each oData update
//   oState         INIT=00, RUN=01, DONE=10
`timescale 1ns/100ps
module control_cmd #(
  parameter int unsigned INIT_CYCLES = 8,
  parameter int unsigned PERIOD      = 4,
  parameter logic [31:0] LIMIT       = 32'd16
) (
  input  logic        iClock,
  input  logic        iReset,
  output logic        oPaseePorReset,
  output logic [31:0] oData,
  output logic        oValid,
  output logic [1:0]  oState
);
  typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam logic [7:0]  INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [15:0] PER_LAST  = 16'(PERIOD - 1);
  state_t      r_state, w_next;
  logic [7:0]  r_init;
  logic [15:0] r_presc;
  logic [31:0] r_data;
  logic        r_valid, r_flag;
  logic        w_init_done, w_wrap, w_last;
  assign w_init_done = r_init == INIT_LAST;
  assign w_wrap      = r_state == RUN && r_presc == PER_LAST;
  // Leaving RUN on the update that reaches LIMIT is what keeps oData from wrapping.
  assign w_last      = r_data + 32'd1 == LIMIT;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == INIT && w_init_done) ? RUN :
             (w_wrap && w_last)               ? DONE : r_state;
  end
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state <= INIT;
      r_init  <= '0;
      r_presc <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_flag  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_init  <= (r_state == INIT && !w_init_done) ? r_init + 8'd1 : '0;
      r_presc <= (r_state == RUN && !w_wrap) ? r_presc + 16'd1 : '0;
      r_data  <= w_wrap ? r_data + 32'd1 : r_data;
      r_valid <= w_wrap;
    end
  end
  assign oPaseePorReset = r_flag;
  assign oData          = r_data;
  assign oValid         = r_valid;
  assign oState         = r_state;
endmodule

// File: tb/tb_control_cmd.sv
// tb_control_cmd: randomized reset/run stimulus on three control_cmd configurations checked against an edge-count model.
`timescale 1ns/100ps
module tb_control_cmd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   e = 0;
  int   checks = 0;
  int   errors = 0;
  bit   big_on = 1'b1;
  logic [31:0] m_data, p_data, b_data;
  logic        m_valid, p_valid, b_valid, m_flag, p_flag, b_flag;
  logic [1:0]  m_state, p_state, b_state;
  logic [31:0] exp_d [7] = '{32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic        exp_v [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  exp_s [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};

  always #1 clk = ~clk;

  control_cmd dut (
    .iClock(clk), .iReset(rst), .oPaseePorReset(m_flag),
    .oData(m_data), .oValid(m_valid), .oState(m_state)
  );
  control_cmd #(.INIT_CYCLES(1), .PERIOD(1), .LIMIT(32'd3)) dut_p1 (
    .iClock(clk), .iReset(rst), .oPaseePorReset(p_flag),
    .oData(p_data), .oValid(p_valid), .oState(p_state)
  );
  control_cmd #(.INIT_CYCLES(2), .PERIOD(2), .LIMIT(32'hFFFFFFFF)) dut_big (
    .iClock(clk), .iReset(rst), .oPaseePorReset(b_flag),
    .oData(b_data), .oValid(b_valid), .oState(b_state)
  );

  // Expected outputs after e clock edges since reset release: update k lands on edge ic+k*per.
  function automatic void model(input int ed, input int ic, input int per, input longint lim,
                                output logic [31:0] d, output logic v, output logic [1:0] s);
    longint k;
    k = (ed < ic) ? 0 : longint'((ed - ic) / per);
    d = 32'(k < lim ? k : lim);
    v = ed >= ic + per && (ed - ic) % per == 0 && k <= lim;
    s = ed < ic ? 2'b00 : (k >= lim ? 2'b10 : 2'b01);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] d;
    logic v;
    logic [1:0] s;
    model(e, 8, 4, 64'd16, d, v, s);
    check("main.oData", m_data, d);
    check("main.oValid", 32'(m_valid), 32'(v));
    check("main.oState", 32'(m_state), 32'(s));
    check("main.flag", 32'(m_flag), 32'd1);
    model(e, 1, 1, 64'd3, d, v, s);
    check("p1.oData", p_data, d);
    check("p1.oValid", 32'(p_valid), 32'(v));
    check("p1.oState", 32'(p_state), 32'(s));
    check("p1.flag", 32'(p_flag), 32'd1);
    if (big_on) begin
      model(e, 2, 2, 64'hFFFFFFFF, d, v, s);
      check("big.oData", b_data, d);
      check("big.oValid", 32'(b_valid), 32'(v));
      check("big.oState", 32'(b_state), 32'(s));
    end
    check("big.flag", 32'(b_flag), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) e++;
    @(negedge clk);
    check_all();
  endtask

  // Reset raised between edges; outputs must clear before any further clock edge.
  task automatic async_reset(input int hold);
    @(posedge clk);
    #(real'($urandom_range(1, 8)) / 10.0);
    rst = 1'b1;
    e = 0;
    #0.1;
    check_all();
    repeat (hold) step();
    rst = 1'b0;
  endtask

  initial begin
    #0.1 rst = 1'b1;
    #0.4 check_all();
    repeat (2) step();
    rst = 1'b0;
    repeat (100) step();
    repeat (6) begin
      repeat ($urandom_range(1, 90)) step();
      async_reset($urandom_range(1, 3));
    end
    repeat (30) step();
    check("main.mid_data", m_data, 32'd5);
    check("main.mid_presc", 32'(dut.r_presc), 32'd2);
    async_reset(1);
    repeat (80) step();
    check("main.done_state", 32'(m_state), 32'd2);
    async_reset(2);
    repeat (4) step();
    big_on = 1'b0;
    force dut_big.r_data = 32'hFFFFFFFD;
    #0.1 release dut_big.r_data;
    #0.1 check("big.forced", b_data, 32'hFFFFFFFD);
    for (int i = 0; i < 7; i++) begin
      step();
      check("big.end_data", b_data, exp_d[i]);
      check("big.end_valid", 32'(b_valid), 32'(exp_v[i]));
      check("big.end_state", 32'(b_state), 32'(exp_s[i]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_cmd.md
CONTROL_CMD -- requirements
Module: control_cmd

Interface
REQ-001 Parameter INIT_CYCLES, default 8, number of clock edges spent in INIT after reset release; legal range 1..255.
REQ-002 Parameter PERIOD, default 4, clock edges between successive count updates in RUN; legal range 1..65535.
REQ-003 Parameter LIMIT, default 32'd16, final count value; legal range 1..32'hFFFFFFFF.
REQ-004 iClock  input  1  single clock; all state updates on its rising edge.
REQ-005 iReset  input  1  asynchronous, active-high reset.
REQ-006 oPaseePorReset  output  1  sticky flag: block has passed through reset.
REQ-007 oData  output  32  current count value.
REQ-008 oValid  output  1  one-cycle strobe, high in the cycle after oData updates.
REQ-009 oState  output  2  FSM state encoding: INIT=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 unused.

Function
REQ-010 The FSM SHALL have exactly three states: INIT, RUN and DONE.
REQ-011 In INIT, an 8-bit init counter SHALL increment each edge; on the edge where it equals INIT_CYCLES-1, the FSM SHALL move to RUN and the counter SHALL clear.
REQ-012 On RUN entry, a 16-bit prescaler SHALL start at 0 and increment each edge, wrapping to 0 on the edge where it equals PERIOD-1.
REQ-013 On each prescaler wrap edge in RUN, oData SHALL increment by 1 and oValid SHALL be 1 for exactly the following cycle; otherwise oValid SHALL be 0.
REQ-014 PERIOD=1 SHALL give one update per edge, with oValid held high continuously in RUN.
REQ-015 On the edge where oData becomes LIMIT, the FSM SHALL move to DONE; that update SHALL still produce its oValid pulse.
REQ-016 In DONE, oData SHALL hold LIMIT, oValid SHALL be 0 after the final pulse, and the FSM SHALL stay in DONE until reset.
REQ-017 oData SHALL never wrap; with LIMIT=32'hFFFFFFFF, the FSM SHALL stop at 32'hFFFFFFFF.
REQ-018 First oValid SHALL occur INIT_CYCLES+PERIOD edges after reset release, with oData=1; update k SHALL occur at edge INIT_CYCLES+k*PERIOD.
REQ-019 oData, oValid and oState SHALL be driven from registers only, with no combinational path from iReset other than the asynchronous clear.

Reset
REQ-020 While iReset=1, outputs SHALL be: oState=INIT, oData=0, oValid=0, init counter=0, prescaler=0 and oPaseePorReset=1, all regardless of iClock.
REQ-021 Reset assertion at any point (INIT, RUN, DONE, or mid-prescaler) SHALL clear state immediately and asynchronously, without waiting for a clock edge.
REQ-022 oPaseePorReset SHALL be set by reset, never cleared by logic, and SHALL remain 1 after iReset deasserts.
REQ-023 The first rising edge with iReset=0 SHALL count as INIT edge 1.

Verification
REQ-024 Defaults, 2 ns clock, reset pulse 4 ns -> oPaseePorReset=1; first oValid 12 edges after release with oData=1; oData=2 at edge 16.
REQ-025 Defaults, run 100 edges after release -> oData increments 1..16 with exactly 16 oValid pulses; oState=DONE after edge 72; oData holds 16.
REQ-026 Reset asserted mid-RUN while oData=5 and prescaler=2 -> same cycle oData=0, oValid=0, oState=INIT; after release the sequence repeats from REQ-024.
REQ-027 PERIOD=1, LIMIT=3, INIT_CYCLES=1 -> oValid high for 3 consecutive cycles with oData 1,2,3, then 0; oState=DONE.
REQ-028 Reset asserted asynchronously between clock edges while in DONE -> outputs clear immediately, with no edge required; oPaseePorReset remains 1.
REQ-029 LIMIT=32'hFFFFFFFF, with oData preloaded through a hierarchical force to 32'hFFFFFFFD in RUN -> pulses at FFFFFFFE and FFFFFFFF, then DONE with no wrap to 0.
